phy_tx_arbiter: RTL and testbench

//  Shares the PHY TX block slot between the network FIFO (net_fifo_buf) and the memory-traffic FIFO.

---
 rtl/phy_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_phy_tx_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/phy_tx_arbiter.sv
// Shares the PHY TX block slot between the network FIFO and the memory FIFO. Latency 1 (block chosen now, registered to tx next clk).
// No upstream backpressure: each FIFO is popped only when its head is sent, and an empty FIFO mid-frame or mid-message is padded with ERR blocks.
module phy_tx_arbiter #(
    parameter int DWIDTH      = 64,
    parameter int CWIDTH      = 2,
    parameter int LVL_W       = 4,
    parameter int MEM_BLKS    = 4,
    parameter int MAX_MEM_RUN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              net_empty,
    input  logic [DWIDTH-1:0] net_data_d,
    input  logic [CWIDTH-1:0] net_data_c,
    output logic              net_rd,
    input  logic              mem_empty,
    input  logic [LVL_W-1:0]  mem_level,
    input  logic [DWIDTH-1:0] mem_data_d,
    input  logic [CWIDTH-1:0] mem_data_c,
    output logic              mem_rd,
    output logic [DWIDTH-1:0] tx_data_d,
    output logic [CWIDTH-1:0] tx_data_c,
    output logic              grant_net,
    output logic              grant_mem,
    output logic              net_underrun,
    output logic              mem_underrun
);
    localparam int BW = $clog2(MEM_BLKS) + 1;
    localparam int SW = $clog2(MAX_MEM_RUN + 1);

    localparam logic [CWIDTH-1:0] CTRL_HDR  = CWIDTH'(2'b01);
    localparam logic [DWIDTH-1:0] IDLE_D    = DWIDTH'(64'h1E);
    localparam logic [DWIDTH-1:0] ERR_D     = {(DWIDTH/8){8'h1E}};
    localparam logic [BW-1:0]     BLK_LAST  = BW'(MEM_BLKS - 1);
    localparam logic [SW-1:0]     STARVE_MX = SW'(MAX_MEM_RUN);
    localparam logic [LVL_W-1:0]  MEM_NEED  = LVL_W'(MEM_BLKS);

    typedef enum logic [1:0] {S_IDLE, S_NET, S_MEM} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     blk_cnt_q, blk_cnt_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [DWIDTH-1:0] tx_dat_q, tx_dat_d;
    logic [CWIDTH-1:0] tx_hdr_q, tx_hdr_d;
    logic              net_ur_q, net_ur_d;
    logic              mem_ur_q, mem_ur_d;

    logic mem_ok, net_ok, starve, net_term;

    assign mem_ok   = (mem_level >= MEM_NEED) && !mem_empty;
    assign net_ok   = !net_empty;
    assign starve   = (starve_cnt_q == STARVE_MX);
    assign net_term = (net_data_c == CTRL_HDR) && (net_data_d[7:0] > 8'h86);

    always_comb begin
        state_d      = state_q;
        blk_cnt_d    = blk_cnt_q;
        starve_cnt_d = starve_cnt_q;
        tx_dat_d     = IDLE_D;
        tx_hdr_d     = CTRL_HDR;
        net_rd       = 1'b0;
        mem_rd       = 1'b0;
        net_ur_d     = 1'b0;
        mem_ur_d     = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    if (mem_ok && !(net_ok && starve)) begin
                        mem_rd   = 1'b1;
                        tx_dat_d = mem_data_d;
                        tx_hdr_d = mem_data_c;
                        if (MEM_BLKS == 1) begin
                            state_d   = S_IDLE;
                            blk_cnt_d = '0;
                        end else begin
                            state_d   = S_MEM;
                            blk_cnt_d = BW'(1);
                        end
                        // Only count runs that actually keep a waiting net frame out
                        if (net_ok)
                            starve_cnt_d = starve ? starve_cnt_q : starve_cnt_q + 1'b1;
                        else
                            starve_cnt_d = '0;
                    end else if (net_ok) begin
                        net_rd       = 1'b1;
                        tx_dat_d     = net_data_d;
                        tx_hdr_d     = net_data_c;
                        starve_cnt_d = '0;
                        state_d      = net_term ? S_IDLE : S_NET;
                    end
                end
                S_NET: begin
                    if (net_ok) begin
                        net_rd   = 1'b1;
                        tx_dat_d = net_data_d;
                        tx_hdr_d = net_data_c;
                        if (net_term)
                            state_d = S_IDLE;
                    end else begin
                        tx_dat_d = ERR_D;
                        net_ur_d = 1'b1;
                    end
                end
                S_MEM: begin
                    if (!mem_empty) begin
                        mem_rd   = 1'b1;
                        tx_dat_d = mem_data_d;
                        tx_hdr_d = mem_data_c;
                        if (blk_cnt_q == BLK_LAST) begin
                            state_d   = S_IDLE;
                            blk_cnt_d = '0;
                        end else begin
                            blk_cnt_d = blk_cnt_q + 1'b1;
                        end
                    end else begin
                        tx_dat_d = ERR_D;
                        mem_ur_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            blk_cnt_q    <= '0;
            starve_cnt_q <= '0;
            tx_dat_q     <= IDLE_D;
            tx_hdr_q     <= CTRL_HDR;
            net_ur_q     <= 1'b0;
            mem_ur_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_cnt_q    <= blk_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            tx_dat_q     <= tx_dat_d;
            tx_hdr_q     <= tx_hdr_d;
            net_ur_q     <= net_ur_d;
            mem_ur_q     <= mem_ur_d;
        end
    end

    assign tx_data_d    = tx_dat_q;
    assign tx_data_c    = tx_hdr_q;
    assign grant_net    = (state_q == S_NET);
    assign grant_mem    = (state_q == S_MEM);
    assign net_underrun = net_ur_q;
    assign mem_underrun = mem_ur_q;

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Directed bench for phy_tx_arbiter: show-ahead FIFO heads come from queues, popped when the DUT strobes rd.
module tb_phy_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        net_empty = 1'b1;
    logic [63:0] net_data_d = '0;
    logic [1:0]  net_data_c = '0;
    logic        net_rd;
    logic        mem_empty = 1'b1;
    logic [3:0]  mem_level = '0;
    logic [63:0] mem_data_d = '0;
    logic [1:0]  mem_data_c = '0;
    logic        mem_rd;
    logic [63:0] tx_data_d;
    logic [1:0]  tx_data_c;
    logic        grant_net, grant_mem, net_underrun, mem_underrun;

    phy_tx_arbiter dut (
        .clk(clk), .reset(reset),
        .net_empty(net_empty), .net_data_d(net_data_d), .net_data_c(net_data_c), .net_rd(net_rd),
        .mem_empty(mem_empty), .mem_level(mem_level), .mem_data_d(mem_data_d), .mem_data_c(mem_data_c),
        .mem_rd(mem_rd), .tx_data_d(tx_data_d), .tx_data_c(tx_data_c),
        .grant_net(grant_net), .grant_mem(grant_mem),
        .net_underrun(net_underrun), .mem_underrun(mem_underrun)
    );

    always #5 clk = ~clk;

    localparam logic [65:0] IDLE_BLK = {2'b01, 64'h0000_0000_0000_001E};
    localparam logic [65:0] ERR_BLK  = {2'b01, 64'h1E1E_1E1E_1E1E_1E1E};

    logic [65:0] netq[$];
    logic [65:0] memq[$];
    logic [65:0] expq[$];
    bit          net_hold = 1'b0;
    bit          mem_hold = 1'b0;
    logic        nr, mr;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [65:0] nd(input int i);
        return {2'b10, 64'hA0A0_0000_0000_0000 | 64'(i)};
    endfunction
    function automatic logic [65:0] nt(input int i);
        return {2'b01, 48'h0, 8'(i), 8'h87};
    endfunction
    function automatic logic [65:0] md(input int i);
        return {2'b10, 64'hB0B0_0000_0000_0000 | 64'(i)};
    endfunction

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: present FIFO heads, capture rd strobes, clock, pop what was read.
    task automatic step();
        net_empty = (netq.size() == 0) || net_hold;
        {net_data_c, net_data_d} = (netq.size() != 0) ? netq[0] : 66'h0;
        mem_empty = (memq.size() == 0) || mem_hold;
        mem_level = mem_hold ? 4'd0 : ((memq.size() > 15) ? 4'd15 : 4'(memq.size()));
        {mem_data_c, mem_data_d} = (memq.size() != 0) ? memq[0] : 66'h0;
        #1;
        nr = net_rd;
        mr = mem_rd;
        chk("rd_exclusive", {65'h0, nr & mr}, 66'h0);
        @(posedge clk);
        #1;
        if (nr) void'(netq.pop_front());
        if (mr) void'(memq.pop_front());
    endtask

    task automatic step_exp(input string tag, input logic [65:0] exp);
        step();
        chk(tag, {tx_data_c, tx_data_d}, exp);
    endtask

    task automatic drain_exp(input string tag);
        while (expq.size() != 0) step_exp(tag, expq.pop_front());
    endtask

    initial begin
        // T1: reset then idle with both FIFOs empty
        reset = 1'b1;
        step();
        step();
        chk("t1_reset_tx", {tx_data_c, tx_data_d}, IDLE_BLK);
        chk("t1_reset_flags", {62'h0, grant_net, grant_mem, net_underrun, mem_underrun}, 66'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_exp("t1_idle_tx", IDLE_BLK);
            chk("t1_idle_rd", {64'h0, nr, mr}, 66'h0);
        end

        // T2: single net frame, mem empty
        for (int i = 0; i < 5; i++) netq.push_back(nd(i));
        netq.push_back(nt(0));
        step_exp("t2_d0", nd(0));
        chk("t2_grant_net", {65'h0, grant_net}, 66'h1);
        for (int i = 1; i < 5; i++) step_exp("t2_dn", nd(i));
        step_exp("t2_term", nt(0));
        chk("t2_back_idle", {64'h0, grant_net, grant_mem}, 66'h0);
        step_exp("t2_after", IDLE_BLK);

        // T3: mem message and net frame ready together -> mem first
        for (int i = 0; i < 4; i++) memq.push_back(md(i));
        netq.push_back(nd(10)); netq.push_back(nd(11)); netq.push_back(nt(1));
        step_exp("t3_m0", md(0));
        chk("t3_grant_mem", {64'h0, grant_mem, grant_net}, 66'h2);
        for (int i = 1; i < 4; i++) step_exp("t3_mn", md(i));
        step_exp("t3_n0", nd(10));
        chk("t3_grant_net", {64'h0, grant_mem, grant_net}, 66'h1);
        step_exp("t3_n1", nd(11));
        step_exp("t3_term", nt(1));
        step_exp("t3_after", IDLE_BLK);

        // T4: both always pending -> mem, mem, net frame repeating
        for (int i = 0; i < 16; i++) memq.push_back(md(100 + i));
        netq.push_back(nd(20)); netq.push_back(nt(2));
        netq.push_back(nd(21)); netq.push_back(nt(3));
        for (int i = 0; i < 8; i++) expq.push_back(md(100 + i));
        expq.push_back(nd(20)); expq.push_back(nt(2));
        for (int i = 8; i < 16; i++) expq.push_back(md(100 + i));
        expq.push_back(nd(21)); expq.push_back(nt(3));
        expq.push_back(IDLE_BLK);
        drain_exp("t4_pattern");

        // T5: net FIFO runs dry mid-frame while a full mem message waits
        netq.push_back(nd(30)); netq.push_back(nd(31)); netq.push_back(nd(32)); netq.push_back(nt(4));
        step_exp("t5_d0", nd(30));
        step_exp("t5_d1", nd(31));
        for (int i = 0; i < 4; i++) memq.push_back(md(200 + i));
        net_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_exp("t5_err", ERR_BLK);
            chk("t5_underrun", {63'h0, net_underrun, grant_net, mr}, 66'h6);
        end
        net_hold = 1'b0;
        step_exp("t5_d2", nd(32));
        chk("t5_underrun_clr", {65'h0, net_underrun}, 66'h0);
        step_exp("t5_term", nt(4));
        for (int i = 0; i < 4; i++) step_exp("t5_mem", md(200 + i));
        step_exp("t5_after", IDLE_BLK);

        // T6: reset in the middle of a mem message
        for (int i = 0; i < 4; i++) memq.push_back(md(300 + i));
        step_exp("t6_m0", md(300));
        step_exp("t6_m1", md(301));
        reset = 1'b1;
        step_exp("t6_reset_tx", IDLE_BLK);
        chk("t6_reset_rd", {64'h0, nr, mr}, 66'h0);
        chk("t6_reset_grant", {64'h0, grant_net, grant_mem}, 66'h0);
        reset = 1'b0;
        step_exp("t6_level_low", IDLE_BLK);
        memq.push_back(md(304)); memq.push_back(md(305));
        for (int i = 2; i < 6; i++) step_exp("t6_full_msg", md(300 + i));
        step_exp("t6_after", IDLE_BLK);

        // T7: mem FIFO runs dry mid-message; block count must hold
        for (int i = 0; i < 4; i++) memq.push_back(md(400 + i));
        step_exp("t7_m0", md(400));
        mem_hold = 1'b1;
        step_exp("t7_err", ERR_BLK);
        chk("t7_underrun", {64'h0, mem_underrun, grant_mem}, 66'h3);
        mem_hold = 1'b0;
        for (int i = 1; i < 4; i++) step_exp("t7_mn", md(400 + i));
        chk("t7_underrun_clr", {65'h0, mem_underrun}, 66'h0);
        step_exp("t7_after", IDLE_BLK);
        chk("t7_grant_idle", {64'h0, grant_net, grant_mem}, 66'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
